// File: rtl/simd_frac_align_pipe_if.sv
// Valid/ready bus for the SIMD leading-one detector / fraction aligner.
// The master side feeds operands and drains results; the slave side is the pipeline.
interface simd_frac_align_pipe_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned LGN   = 5,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [N-1:0]     in_a;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_frac;
  logic [4*LGN-1:0] out_pos;
  logic [3:0]       out_zero;
  logic [1:0]       out_mode;
  logic             out_err;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_mode, in_a, in_tag, out_ready,
    input  in_ready, out_valid, out_frac, out_pos, out_zero, out_mode, out_err, out_tag
  );

  modport slave (
    input  in_valid, in_mode, in_a, in_tag, out_ready,
    output in_ready, out_valid, out_frac, out_pos, out_zero, out_mode, out_err, out_tag
  );
endinterface

// File: rtl/simd_frac_align_pipe.sv
// Two-stage SIMD leading-one detector and fraction aligner (1, 2 or 4 lanes per word).
// Stage 1 finds per-lane leading-one positions; stage 2 left-aligns each lane.
module simd_frac_align_pipe #(
  parameter int unsigned N     = 32,
  parameter int unsigned LGN   = 5,
  parameter int unsigned TAG_W = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  simd_frac_align_pipe_if.slave  bus
);

  // {found, position} of the highest set bit within the low w bits of v.
  function automatic logic [LGN:0] lead_one(input logic [N-1:0] v, input int unsigned w);
    logic [LGN:0] r;
    r = '0;
    for (int unsigned b = 0; b < N; b++) begin
      if (b < w && v[b]) r = {1'b1, LGN'(b)};
    end
    return r;
  endfunction

  logic             s1_valid_q, s2_valid_q;
  logic             s1_adv, s2_adv;
  logic [1:0]       in_eff_mode, s1_eff_mode;
  logic [LGN:0]     lo;
  logic [N-1:0]     sh;
  logic [4*LGN-1:0] s1_pos_d, s1_pos_q, s2_pos_q;
  logic [3:0]       s1_zero_d, s1_zero_q, s2_zero_q;
  logic [N-1:0]     s1_a_q, s2_frac_d, s2_frac_q;
  logic [1:0]       s1_mode_q, s2_mode_q;
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q;
  logic             s2_err_q;

  assign s2_adv       = !s2_valid_q || bus.out_ready;
  assign s1_adv       = !s1_valid_q || s2_adv;
  assign bus.in_ready = s1_adv;

  // Reserved mode 3 is processed as a single full-width lane.
  assign in_eff_mode = (bus.in_mode == 2'd3) ? 2'd0 : bus.in_mode;
  assign s1_eff_mode = (s1_mode_q == 2'd3) ? 2'd0 : s1_mode_q;

  always_comb begin
    s1_pos_d  = '0;
    s1_zero_d = '0;
    lo        = '0;
    case (in_eff_mode)
      2'd1: begin
        for (int i = 0; i < 2; i++) begin
          lo = lead_one(bus.in_a >> (i * (N / 2)), N / 2);
          s1_pos_d[i*LGN +: LGN] = lo[LGN-1:0];
          s1_zero_d[i]           = !lo[LGN];
        end
      end
      2'd2: begin
        for (int i = 0; i < 4; i++) begin
          lo = lead_one(bus.in_a >> (i * (N / 4)), N / 4);
          s1_pos_d[i*LGN +: LGN] = lo[LGN-1:0];
          s1_zero_d[i]           = !lo[LGN];
        end
      end
      default: begin
        lo           = lead_one(bus.in_a, N);
        s1_pos_d[LGN-1:0] = lo[LGN-1:0];
        s1_zero_d[0] = !lo[LGN];
      end
    endcase
  end

  // Bits above a lane shift out of its slice, so no masking is needed.
  always_comb begin
    s2_frac_d = '0;
    sh        = '0;
    case (s1_eff_mode)
      2'd1: begin
        for (int i = 0; i < 2; i++) begin
          sh = (s1_a_q >> (i * (N / 2))) << (LGN'(N / 2 - 1) - s1_pos_q[i*LGN +: LGN]);
          s2_frac_d[i*(N/2) +: N/2] = sh[N/2-1:0];
        end
      end
      2'd2: begin
        for (int i = 0; i < 4; i++) begin
          sh = (s1_a_q >> (i * (N / 4))) << (LGN'(N / 4 - 1) - s1_pos_q[i*LGN +: LGN]);
          s2_frac_d[i*(N/4) +: N/4] = sh[N/4-1:0];
        end
      end
      default: begin
        sh        = s1_a_q << (LGN'(N - 1) - s1_pos_q[LGN-1:0]);
        s2_frac_d = sh;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_pos_q   <= '0;
      s1_zero_q  <= '0;
      s1_a_q     <= '0;
      s1_mode_q  <= '0;
      s1_tag_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_pos_q  <= s1_pos_d;
        s1_zero_q <= s1_zero_d;
        s1_a_q    <= bus.in_a;
        s1_mode_q <= bus.in_mode;
        s1_tag_q  <= bus.in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_frac_q  <= '0;
      s2_pos_q   <= '0;
      s2_zero_q  <= '0;
      s2_mode_q  <= '0;
      s2_err_q   <= 1'b0;
      s2_tag_q   <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_frac_q <= s2_frac_d;
        s2_pos_q  <= s1_pos_q;
        s2_zero_q <= s1_zero_q;
        s2_mode_q <= s1_mode_q;
        s2_err_q  <= (s1_mode_q == 2'd3);
        s2_tag_q  <= s1_tag_q;
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_frac  = s2_frac_q;
  assign bus.out_pos   = s2_pos_q;
  assign bus.out_zero  = s2_zero_q;
  assign bus.out_mode  = s2_mode_q;
  assign bus.out_err   = s2_err_q;
  assign bus.out_tag   = s2_tag_q;

endmodule

// File: tb/tb_simd_frac_align_pipe.sv
// Bench for simd_frac_align_pipe: directed vectors, a stall/stream case, mid-flight reset
// and randomized traffic, all scored against an arithmetic lane model.
module tb_simd_frac_align_pipe;
  localparam int unsigned N     = 32;
  localparam int unsigned LGN   = 5;
  localparam int unsigned TAG_W = 4;

  typedef struct packed {
    logic [N-1:0]     frac;
    logic [4*LGN-1:0] pos;
    logic [3:0]       zero;
    logic [1:0]       mode;
    logic             err;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   out_cnt  = 0;
  exp_t sb_q[$];

  simd_frac_align_pipe_if #(.N(N), .LGN(LGN), .TAG_W(TAG_W)) bus ();

  simd_frac_align_pipe #(.N(N), .LGN(LGN), .TAG_W(TAG_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Lane-by-lane reference: find the top set bit and shift it up to the lane MSB.
  function automatic exp_t model(input logic [1:0] mode, input logic [N-1:0] a,
                                 input logic [TAG_W-1:0] tag);
    exp_t r;
    int lanes, w, p;
    longint unsigned lane, mask, f;
    r     = '0;
    r.mode = mode;
    r.tag  = tag;
    r.err  = (mode == 2'd3);
    lanes = (mode == 2'd3) ? 1 : (1 << mode);
    w     = N / lanes;
    mask  = (64'd1 << w) - 1;
    for (int i = 0; i < lanes; i++) begin
      lane = (longint'(a) >> (i * w)) & mask;
      if (lane == 0) begin
        r.zero[i] = 1'b1;
      end else begin
        p = w - 1;
        while (((lane >> p) & 1) == 0) p--;
        r.pos[i*LGN +: LGN] = LGN'(p);
        f = ((lane << (w - 1 - p)) & mask) << (i * w);
        r.frac = r.frac | N'(f);
      end
    end
    return r;
  endfunction

  // Monitor: sampled on the falling edge, where inputs and outputs are settled.
  logic held = 1'b0;
  exp_t snap;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("stall_hold", {bus.out_valid, bus.out_frac, bus.out_pos, bus.out_zero},
              {1'b1, snap.frac, snap.pos, snap.zero});
        check("stall_side", {bus.out_mode, bus.out_err, bus.out_tag},
              {snap.mode, snap.err, snap.tag});
      end
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (sb_q.size() == 0) begin
          check("unexpected_out", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("frac", 64'(bus.out_frac), 64'(e.frac));
          check("pos",  64'(bus.out_pos),  64'(e.pos));
          check("zero_err_mode_tag", {bus.out_zero, bus.out_err, bus.out_mode, bus.out_tag},
                {e.zero, e.err, e.mode, e.tag});
        end
      end
      held = bus.out_valid && !bus.out_ready;
      snap = {bus.out_frac, bus.out_pos, bus.out_zero, bus.out_mode, bus.out_err, bus.out_tag};
      if (bus.in_valid && bus.in_ready) sb_q.push_back(model(bus.in_mode, bus.in_a, bus.in_tag));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while ((sb_q.size() != 0 || bus.out_valid) && n < 100) begin
      tick();
      n++;
    end
    check(tag, 64'(sb_q.size()), 64'd0);
  endtask

  // Send one word into an empty pipe and check the result exactly two cycles later.
  task automatic direct(input string tag, input logic [1:0] mode, input logic [N-1:0] a,
                        input logic [TAG_W-1:0] t, input logic [N-1:0] ef,
                        input logic [4*LGN-1:0] ep, input logic [3:0] ez, input logic ee);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_mode   = mode;
    bus.in_a      = a;
    bus.in_tag    = t;
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
    tick();
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_frac"}, 64'(bus.out_frac), 64'(ef));
    check({tag, "_pos"}, 64'(bus.out_pos), 64'(ep));
    check({tag, "_zet"}, {bus.out_zero, bus.out_err, bus.out_mode, bus.out_tag},
          {ez, ee, mode, t});
    tick();
  endtask

  initial begin
    logic [1:0]       smode[6];
    logic [N-1:0]     sa[6];
    int idx, c, fire;
    logic saw_low;
    logic pending;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mode   = '0;
    bus.in_a      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    check("rst_outs", {bus.out_frac, bus.out_pos, bus.out_zero, bus.out_mode, bus.out_err,
          bus.out_tag}, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    direct("t1", 2'd0, 32'h0000_1234, 4'd5, 32'h91A0_0000, 20'd12, 4'b0000, 1'b0);
    direct("t2", 2'd1, 32'h8000_0001, 4'd9, 32'h8000_8000, 20'(15 << 5), 4'b0000, 1'b0);
    direct("t3", 2'd2, 32'h0001_7FFF, 4'd3, 32'h0080_FEFF, 20'((6 << 5) | 7), 4'b1000, 1'b0);
    direct("t6a", 2'd3, 32'h0000_0001, 4'd1, 32'h8000_0000, 20'd0, 4'b0000, 1'b1);
    direct("t6b", 2'd0, 32'h0000_0000, 4'd2, 32'h0000_0000, 20'd0, 4'b0001, 1'b0);
    drain("drain_directed");

    // Stream of 6 words with the sink stalled on cycles 3..5.
    for (int i = 0; i < 6; i++) begin
      smode[i] = 2'($urandom_range(0, 2));
      sa[i]    = $urandom;
    end
    idx = 0;
    saw_low = 1'b0;
    out_cnt = 0;
    for (c = 0; c < 40 && (idx < 6 || sb_q.size() != 0); c++) begin
      bus.out_ready = !(c >= 3 && c <= 5);
      bus.in_valid  = (idx < 6);
      bus.in_mode   = (idx < 6) ? smode[idx] : 2'd0;
      bus.in_a      = (idx < 6) ? sa[idx] : '0;
      bus.in_tag    = TAG_W'(idx);
      @(negedge clk);
      fire = int'(bus.in_valid && bus.in_ready);
      if (!bus.in_ready) saw_low = 1'b1;
      tick();
      idx += fire;
    end
    check("stream_inready_low", 64'(saw_low), 64'd1);
    check("stream_count", 64'(out_cnt), 64'd6);
    drain("drain_stream");

    // Reset with both stages occupied.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_mode   = 2'd0;
    bus.in_a      = 32'h0000_00F0;
    tick();
    bus.in_a = 32'h0000_0F00;
    tick();
    bus.in_valid = 1'b0;
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_outs", {bus.out_frac, bus.out_pos, bus.out_zero, bus.out_mode, bus.out_err,
          bus.out_tag}, '0);
    check("midrst_ready", 64'(bus.in_ready), 64'd1);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    direct("t5", 2'd1, 32'h0003_0010, 4'd7, 32'hC000_8000, 20'((1 << 5) | 4), 4'b0000, 1'b0);
    drain("drain_reset");

    // Randomized traffic; an unaccepted word is held until it transfers.
    pending = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (!pending) begin
        bus.in_valid = ($urandom_range(0, 9) < 7);
        bus.in_mode  = 2'($urandom_range(0, 3));
        bus.in_a     = $urandom >> $urandom_range(0, 31);
        for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) bus.in_a[b*8 +: 8] = 8'h00;
        bus.in_tag   = TAG_W'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      pending = bus.in_valid && !bus.in_ready;
      tick();
    end
    drain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
